hyper_mvblck_sched: RTL and testbench
=====================================

# hyper_mvblck_sched

Round-robin scheduler that shares one DRAM-to-LSAB block mover (`hyper_mvblck_frdram`) among four LSAB sections. Each section raises a request carrying a 12-bit DRAM start address and a 5-bit word count. The scheduler grants one section at a time, drives the mover's issue interface, and tracks the mover's `WORKING` envelope. When the transfer is finished it returns a one-cycle completion pulse and the transferred count to the granted section. It sits between the per-section LSAB controllers and the mover, and is the only agent allowed to drive the mover's `ISSUE`.

## Interface

Parameters:
- `WATCHDOG`, default 6'd63: maximum cycles in WAIT_START before the transfer is abandoned; range 3..63.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `REQ`  in  4  per-section request levels; bit n is section n.
- `REQ_ADDRESS`  in  48  start address per section; section n uses bits [12n+11:12n].
- `REQ_COUNT`  in  20  word count per section; section n uses bits [5n+4:5n].
- `GRANT`  out  4  one-hot grant; held from selection until the DONE cycle, inclusive.
- `DONE`  out  4  one-hot, one-cycle completion pulse.
- `DONE_COUNT`  out  5  count reported with DONE; valid only in the DONE cycle.
- `TIMEOUT`  out  1  one-cycle pulse when a transfer is abandoned by the watchdog.
- `BUSY`  out  1  high in every state except IDLE.
- `MV_START_ADDRESS`  out  12  drives the mover's `START_ADDRESS`.
- `MV_COUNT_REQ`  out  5  drives the mover's `COUNT_REQ`.
- `MV_SECTION`  out  2  drives the mover's `SECTION`.
- `MV_ISSUE`  out  1  drives the mover's `ISSUE`; a single-cycle pulse.
- `MV_COUNT_SENT`  in  5  from the mover's `COUNT_SENT`.
- `MV_WORKING`  in  1  from the mover's `WORKING`.

## Operation

- State machine: IDLE, WAIT_START, WAIT_END, DONE.
- Pointer: `last` (2 bits) holds the most recently granted section; its reset value is 2'd3, so section 0 has first priority.
- **IDLE**
  - If any `REQ` bit is set, select the first set bit searching from `last+1` upward, modulo 4.
  - Register the selected section's address and count into `MV_START_ADDRESS` and `MV_COUNT_REQ`; set `MV_SECTION` and `GRANT`.
  - If the selected count is nonzero: assert `MV_ISSUE` for one cycle, clear the watchdog counter, go to WAIT_START.
  - If the selected count is zero: do not issue; go directly to DONE with `DONE_COUNT` = 0.
- **WAIT_START**
  - The watchdog counter increments every cycle.
  - If `MV_WORKING`=1, latch `MV_COUNT_SENT` into the count register and go to WAIT_END.
  - Else, if the counter reaches `WATCHDOG`, pulse `TIMEOUT`, set the count register to 0, and go to DONE.
- **WAIT_END**
  - Wait for `MV_WORKING`=0, then go to DONE.
  - No timeout applies in this state, because the mover always terminates.
- **DONE**
  - `DONE` equals `GRANT` and `DONE_COUNT` equals the count register, for one cycle.
  - Update `last` to the granted section; clear `GRANT`; go to IDLE.
- `REQ` is sampled only in IDLE. Dropping `REQ` during service has no effect; the transfer completes and `DONE` still pulses.
- A requester must hold `REQ` until its `DONE`. If `REQ` is still high after `DONE`, the scheduler treats it as a new request.
- `MV_START_ADDRESS`, `MV_COUNT_REQ` and `MV_SECTION` stay stable from issue until the next grant. They are not cleared on DONE.
- Width rules:
  - The pointer and the section index wrap modulo 4.
  - The watchdog counter is 6 bits and saturates at `WATCHDOG`.
  - Counts pass through unmodified; no arithmetic is applied to them.

## Timing

- Every output is registered.
- Reset value of every output is 0. Internal state resets to IDLE, `last`=3, counters 0.
- Assertion of `RST` aborts any transfer immediately. No `DONE` or `TIMEOUT` is produced for the aborted transfer. The mover shares `RST`.
- Request to issue:
  - `REQ` is sampled in IDLE on edge 0.
  - `GRANT`, `MV_*` and `MV_ISSUE`=1 are valid after edge 0.
  - `MV_ISSUE`=0 after edge 1.
- The mover raises `WORKING` about 2 cycles after issue, so `WATCHDOG` must be at least 3.
- `DONE` is high in the cycle after the edge that samples `MV_WORKING`=0 in WAIT_END.
- Back-to-back transfers: the IDLE cycle follows DONE. The next `MV_ISSUE` occurs 2 edges after the `DONE` edge, giving a minimum gap of 1 idle cycle.
- Zero-count requests: `DONE` follows the grant by exactly 1 cycle.
- If `REQ` arrives in the same cycle as `DONE`, it is sampled in the following IDLE cycle.

## Test plan

1. **Single request.** Reset, then `REQ`=4'b0100, address 12'h123, count 5'd7.
   - `GRANT`=4'b0100, `MV_ISSUE` high for 1 cycle, `MV_SECTION`=2, `MV_START_ADDRESS`=12'h123.
   - After the mover's `WORKING` falls: `DONE`=4'b0100, `DONE_COUNT`=7.
2. **Round robin.** `REQ`=4'b1111 held continuously.
   - Grants occur in order 0,1,2,3,0, with exactly one `MV_ISSUE` per grant and no overlap of `WORKING`.
3. **Zero count.** `REQ`=4'b0001, count 0.
   - No `MV_ISSUE`; `DONE`=4'b0001 and `DONE_COUNT`=0 one cycle after the grant.
4. **Watchdog.** Hold the mover model's `WORKING` at 0 with `WATCHDOG`=5.
   - `TIMEOUT` and `DONE` pulse 5 cycles after issue, with `DONE_COUNT`=0; the scheduler returns to IDLE.
5. **Reset mid-transfer.** Drop `RST` while in WAIT_END.
   - All outputs are 0 immediately, with no `DONE`.
   - After release, `REQ`=4'b1000 is granted; `last` has restarted at 3, so section 0 would have taken priority had it been requesting.
6. **Request withdrawal.** Deassert `REQ` one cycle after `GRANT`.
   - The transfer still completes and `DONE` pulses exactly once.

Source files
------------

// File: rtl/hyper_mvblck_sched.sv
// hyper_mvblck_sched: round-robin arbiter sharing one DRAM-to-LSAB block mover among four LSAB sections
module hyper_mvblck_sched #(
  parameter logic [5:0] WATCHDOG = 6'd63
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  REQ,
  input  logic [47:0] REQ_ADDRESS,
  input  logic [19:0] REQ_COUNT,
  output logic [3:0]  GRANT,
  output logic [3:0]  DONE,
  output logic [4:0]  DONE_COUNT,
  output logic        TIMEOUT,
  output logic        BUSY,
  output logic [11:0] MV_START_ADDRESS,
  output logic [4:0]  MV_COUNT_REQ,
  output logic [1:0]  MV_SECTION,
  output logic        MV_ISSUE,
  input  logic [4:0]  MV_COUNT_SENT,
  input  logic        MV_WORKING
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT_START, S_WAIT_END, S_DONE} state_t;
  state_t state, nxt;
  logic [1:0] last, sel;
  logic [5:0] wd, wd_inc;
  logic [4:0] cnt, sel_cnt;
  logic [11:0] sel_addr;
  logic take, fire, to;
  // first requesting section after last, wrapping; last itself has lowest priority
  always_comb begin
    sel = last;
    for (int i = 4; i >= 1; i--) if (REQ[last + 2'(i)]) sel = last + 2'(i);
    sel_addr = REQ_ADDRESS[12*sel +: 12];
    sel_cnt = REQ_COUNT[5*sel +: 5];
    wd_inc = (wd == WATCHDOG) ? wd : wd + 6'd1;
  end
  // next state; fire marks the edge that launches the DONE pulse
  always_comb begin
    nxt = state;
    take = 1'b0;
    fire = 1'b0;
    to = 1'b0;
    case (state)
      S_IDLE: if (|REQ) begin
        take = 1'b1;
        nxt = (sel_cnt != 5'd0) ? S_WAIT_START : S_DONE;
      end
      S_WAIT_START: if (MV_WORKING) nxt = S_WAIT_END;
        else if (wd_inc == WATCHDOG) begin
          to = 1'b1;
          fire = 1'b1;
          nxt = S_DONE;
        end
      S_WAIT_END: if (!MV_WORKING) begin
        fire = 1'b1;
        nxt = S_DONE;
      end
      default: begin
        fire = (DONE == 4'd0);
        nxt = (DONE == 4'd0) ? S_DONE : S_IDLE;
      end
    endcase
  end
  // state register
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= S_IDLE;
    else state <= nxt;
  // registered outputs, pointer, watchdog and count register
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      last <= 2'd3;
      wd <= 6'd0;
      cnt <= 5'd0;
      GRANT <= 4'd0;
      DONE <= 4'd0;
      DONE_COUNT <= 5'd0;
      TIMEOUT <= 1'b0;
      BUSY <= 1'b0;
      MV_START_ADDRESS <= 12'd0;
      MV_COUNT_REQ <= 5'd0;
      MV_SECTION <= 2'd0;
      MV_ISSUE <= 1'b0;
    end else begin
      wd <= (state == S_WAIT_START) ? wd_inc : 6'd0;
      DONE <= fire ? GRANT : 4'd0;
      DONE_COUNT <= (fire && !to) ? cnt : 5'd0;
      TIMEOUT <= to;
      BUSY <= nxt != S_IDLE;
      MV_ISSUE <= take && sel_cnt != 5'd0;
      if (take) begin
        GRANT <= 4'd1 << sel;
        MV_SECTION <= sel;
        MV_START_ADDRESS <= sel_addr;
        MV_COUNT_REQ <= sel_cnt;
        cnt <= sel_cnt;
      end
      if (state == S_WAIT_START && MV_WORKING) cnt <= MV_COUNT_SENT;
      if (to) cnt <= 5'd0;
      if (state == S_DONE && !fire) begin
        GRANT <= 4'd0;
        last <= MV_SECTION;
      end
    end
endmodule

// File: tb/tb_hyper_mvblck_sched.sv
// tb_hyper_mvblck_sched: directed checks of hyper_mvblck_sched against a small block-mover model
module tb_hyper_mvblck_sched;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [3:0] REQ;
  logic [47:0] REQ_ADDRESS;
  logic [19:0] REQ_COUNT;
  logic [3:0] GRANT, DONE;
  logic [4:0] DONE_COUNT, MV_COUNT_REQ;
  logic TIMEOUT, BUSY, MV_ISSUE;
  logic [11:0] MV_START_ADDRESS;
  logic [1:0] MV_SECTION;
  logic [4:0] MV_COUNT_SENT = 5'd0;
  logic MV_WORKING = 1'b0;
  logic mv_stall;
  logic pend = 1'b0;
  logic [4:0] lat = 5'd0;
  int run = 0;
  int n_issue = 0;
  int n_overlap = 0;
  int n_done = 0;
  int n_chk = 0;
  int n_pass = 0;
  int i0, o0, d0;
  logic [11:0] ea [4] = '{12'hA11, 12'hB22, 12'h123, 12'hC33};
  logic [4:0] ec [4] = '{5'd3, 5'd9, 5'd7, 5'd31};

  hyper_mvblck_sched #(.WATCHDOG(6'd5)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_ADDRESS(REQ_ADDRESS), .REQ_COUNT(REQ_COUNT),
    .GRANT(GRANT), .DONE(DONE), .DONE_COUNT(DONE_COUNT), .TIMEOUT(TIMEOUT), .BUSY(BUSY),
    .MV_START_ADDRESS(MV_START_ADDRESS), .MV_COUNT_REQ(MV_COUNT_REQ), .MV_SECTION(MV_SECTION),
    .MV_ISSUE(MV_ISSUE), .MV_COUNT_SENT(MV_COUNT_SENT), .MV_WORKING(MV_WORKING)
  );

  always #5 CLK = ~CLK;

  // mover model: WORKING rises 2 cycles after ISSUE and stays high 3 cycles
  always @(negedge CLK) begin
    if (!RST) begin
      MV_WORKING = 1'b0;
      MV_COUNT_SENT = 5'd0;
      pend = 1'b0;
      run = 0;
    end else begin
      if (DONE != 4'd0) n_done++;
      if (MV_ISSUE && (MV_WORKING || pend)) n_overlap++;
      if (run != 0) begin
        run--;
        if (run == 0) MV_WORKING = 1'b0;
      end
      if (pend) begin
        pend = 1'b0;
        MV_WORKING = 1'b1;
        MV_COUNT_SENT = lat;
        run = 3;
      end
      if (MV_ISSUE) begin
        n_issue++;
        if (!mv_stall) begin
          pend = 1'b1;
          lat = MV_COUNT_REQ;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input string tag, input logic [3:0] exp_d, input logic [4:0] exp_c);
    int i = 0;
    do begin
      tick;
      i++;
    end while (DONE == 4'd0 && i < 40);
    chk(tag, 32'(DONE), 32'(exp_d));
    chk({tag, "_count"}, 32'(DONE_COUNT), 32'(exp_c));
  endtask

  task automatic do_reset;
    RST = 1'b0;
    REQ = 4'd0;
    tick;
    tick;
    RST = 1'b1;
  endtask

  initial begin
    mv_stall = 1'b0;
    REQ = 4'd0;
    REQ_ADDRESS = {12'hC33, 12'h123, 12'hB22, 12'hA11};
    REQ_COUNT = {5'd31, 5'd7, 5'd9, 5'd3};
    tick;
    tick;
    chk("rst_grant", 32'(GRANT), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_issue", 32'(MV_ISSUE), 0);
    chk("rst_done", 32'(DONE), 0);
    RST = 1'b1;
    tick;
    REQ = 4'b0100;
    tick;
    chk("t1_grant", 32'(GRANT), 4'b0100);
    chk("t1_issue", 32'(MV_ISSUE), 1);
    chk("t1_section", 32'(MV_SECTION), 2);
    chk("t1_addr", 32'(MV_START_ADDRESS), 12'h123);
    chk("t1_count_req", 32'(MV_COUNT_REQ), 7);
    chk("t1_busy", 32'(BUSY), 1);
    tick;
    chk("t1_issue_pulse", 32'(MV_ISSUE), 0);
    repeat (3) begin
      tick;
      chk("t1_no_early_done", 32'(DONE), 0);
    end
    tick;
    chk("t1_done", 32'(DONE), 4'b0100);
    chk("t1_done_count", 32'(DONE_COUNT), 7);
    chk("t1_grant_in_done", 32'(GRANT), 4'b0100);
    REQ = 4'd0;
    tick;
    chk("t1_done_pulse", 32'(DONE), 0);
    chk("t1_grant_clr", 32'(GRANT), 0);
    chk("t1_idle", 32'(BUSY), 0);
    chk("t1_addr_hold", 32'(MV_START_ADDRESS), 12'h123);

    do_reset;
    i0 = n_issue;
    o0 = n_overlap;
    REQ = 4'hF;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) begin
        tick;
        chk("rr_gap", 32'(GRANT), 0);
      end
      tick;
      chk("rr_grant", 32'(GRANT), 1 << (k % 4));
      chk("rr_issue", 32'(MV_ISSUE), 1);
      chk("rr_addr", 32'(MV_START_ADDRESS), 32'(ea[k % 4]));
      if (k == 4) REQ = 4'd0;
      wait_done("rr_done", 4'(1 << (k % 4)), ec[k % 4]);
    end
    tick;
    chk("rr_idle", 32'(BUSY), 0);
    chk("rr_issues", n_issue - i0, 5);
    chk("rr_overlap", n_overlap - o0, 0);

    REQ_COUNT[4:0] = 5'd0;
    REQ = 4'b0001;
    i0 = n_issue;
    tick;
    chk("z_grant", 32'(GRANT), 4'b0001);
    chk("z_no_issue", 32'(MV_ISSUE), 0);
    chk("z_no_done_yet", 32'(DONE), 0);
    tick;
    chk("z_done", 32'(DONE), 4'b0001);
    chk("z_done_count", 32'(DONE_COUNT), 0);
    REQ = 4'd0;
    tick;
    chk("z_done_pulse", 32'(DONE), 0);
    chk("z_grant_clr", 32'(GRANT), 0);
    chk("z_issues", n_issue - i0, 0);

    REQ_COUNT[4:0] = 5'd2;
    mv_stall = 1'b1;
    REQ = 4'b0010;
    tick;
    chk("wd_grant", 32'(GRANT), 4'b0010);
    chk("wd_issue", 32'(MV_ISSUE), 1);
    repeat (4) begin
      tick;
      chk("wd_no_early_to", 32'(TIMEOUT), 0);
      chk("wd_no_early_done", 32'(DONE), 0);
    end
    tick;
    chk("wd_timeout", 32'(TIMEOUT), 1);
    chk("wd_done", 32'(DONE), 4'b0010);
    chk("wd_done_count", 32'(DONE_COUNT), 0);
    REQ = 4'd0;
    tick;
    chk("wd_to_pulse", 32'(TIMEOUT), 0);
    chk("wd_idle", 32'(BUSY), 0);
    mv_stall = 1'b0;

    REQ = 4'b0100;
    tick;
    chk("ra_grant", 32'(GRANT), 4'b0100);
    repeat (3) tick;
    chk("ra_busy", 32'(BUSY), 1);
    d0 = n_done;
    RST = 1'b0;
    #1;
    chk("ra_grant_clr", 32'(GRANT), 0);
    chk("ra_busy_clr", 32'(BUSY), 0);
    chk("ra_addr_clr", 32'(MV_START_ADDRESS), 0);
    chk("ra_section_clr", 32'(MV_SECTION), 0);
    chk("ra_count_req_clr", 32'(MV_COUNT_REQ), 0);
    chk("ra_done_clr", 32'(DONE), 0);
    REQ = 4'd0;
    tick;
    tick;
    RST = 1'b1;
    repeat (4) tick;
    chk("ra_no_done", n_done - d0, 0);
    chk("ra_no_to", 32'(TIMEOUT), 0);
    REQ = 4'b1000;
    tick;
    chk("ra_regrant", 32'(GRANT), 4'b1000);
    chk("ra_section", 32'(MV_SECTION), 3);
    chk("ra_addr", 32'(MV_START_ADDRESS), 12'hC33);
    wait_done("ra_done", 4'b1000, 5'd31);
    REQ = 4'd0;
    tick;

    REQ = 4'b0001;
    tick;
    chk("wr_grant", 32'(GRANT), 4'b0001);
    tick;
    REQ = 4'd0;
    d0 = n_done;
    wait_done("wr_done", 4'b0001, 5'd2);
    repeat (4) tick;
    chk("wr_once", n_done - d0, 1);
    chk("wr_idle", 32'(BUSY), 0);
    chk("wr_grant_clr", 32'(GRANT), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end
endmodule
